// File: rtl/controle_banco_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controle_pkg
//  Description : Shared opcodes, FSM state encoding, instruction field
//                positions and opcode classification helpers for the
//                register-bank instruction sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package controle_pkg;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

  // Instruction field positions: [15:12]=op [11:8]=rd [7:4]=rs1 [3:0]=rs2
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int IMM_LSB = 0;

  localparam logic [FIELD_W-1:0] OP_NOP  = 4'h0;
  localparam logic [FIELD_W-1:0] OP_ADD  = 4'h1;
  localparam logic [FIELD_W-1:0] OP_SUB  = 4'h2;
  localparam logic [FIELD_W-1:0] OP_AND  = 4'h3;
  localparam logic [FIELD_W-1:0] OP_OR   = 4'h4;
  localparam logic [FIELD_W-1:0] OP_LI   = 4'h5;
  localparam logic [FIELD_W-1:0] OP_MOV  = 4'h6;
  localparam logic [FIELD_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Opcodes that produce a bank write-back
  function automatic logic op_writes(input logic [FIELD_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

  // Arithmetic/logic opcodes that refresh the zero flag
  function automatic logic op_sets_zero(input logic [FIELD_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  // Undefined opcodes 7..E: retired as NOP but flagged
  function automatic logic op_illegal(input logic [FIELD_W-1:0] op);
    return (op > OP_MOV) && (op < OP_HALT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/controle_banco_if.sv
`default_nettype none
// ============================================================================
//  Module      : controle_banco_if
//  Description : Instruction valid/ready handshake between the instruction
//                source (master) and the sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface controle_banco_if;
  import controle_pkg::*;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);

endinterface
`default_nettype wire

// File: rtl/controle_banco_ula.sv
`default_nettype none
// ============================================================================
//  Module      : ula
//  Description : Combinational ALU of the sequencer. Computes the write-back
//                value for every opcode and a result==0 flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ula
  import controle_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [FIELD_W-1:0] op,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [IMM_W-1:0]   imm8,
  output logic [DATA_W-1:0]  result,
  output logic               zero
);

  // Opcode decode; non-writing opcodes yield 0 (value is never stored)
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_LI:   result = DATA_W'(imm8);
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/controle_banco.sv
`default_nettype none
// ============================================================================
//  Module      : controle_banco
//  Description : Multi-cycle instruction sequencer for a 16x16 register bank.
//                Accepts an instruction, reads two operands through the
//                bank's asynchronous read ports, computes the result and
//                issues one registered write-back per writing instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_banco
  import controle_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  controle_banco_if.slave    bus,
  output logic [ADDR_W-1:0]  endereco_reg1,
  output logic [ADDR_W-1:0]  endereco_reg2,
  input  logic [DATA_W-1:0]  conteudo_reg1,
  input  logic [DATA_W-1:0]  conteudo_reg2,
  output logic [ADDR_W-1:0]  endereco_escrita,
  output logic [DATA_W-1:0]  conteudo_escrita,
  output logic               enable,
  output logic               zero,
  output logic               illegal,
  output logic               halted,
  output logic [COUNT_W-1:0] retired
);

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [ADDR_W-1:0]   endereco_escrita_q, endereco_escrita_d;
  logic [DATA_W-1:0]   conteudo_escrita_q, conteudo_escrita_d;
  logic                enable_q, enable_d;
  logic                zero_q, zero_d;
  logic                illegal_q, illegal_d;
  logic [COUNT_W-1:0]  retired_q, retired_d;

  logic [FIELD_W-1:0]  op;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_zero;
  logic                ready;

  assign op = ir_q[OP_LSB +: FIELD_W];

  // Read addresses come straight from IR, so operands are valid during EXEC
  assign endereco_reg1 = ADDR_W'(ir_q[RS1_LSB +: FIELD_W]);
  assign endereco_reg2 = ADDR_W'(ir_q[RS2_LSB +: FIELD_W]);

  ula #(
    .DATA_W (DATA_W)
  ) u_ula (
    .op     (op),
    .a      (conteudo_reg1),
    .b      (conteudo_reg2),
    .imm8   (ir_q[IMM_LSB +: IMM_W]),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Not ready while reset is held, so nothing is offered during reset
  assign ready           = (state_q == ST_IDLE) && rst_n;
  assign bus.instr_ready = ready;

  // Next-state and datapath updates; every register holds by default
  always_comb begin
    state_d            = state_q;
    ir_d               = ir_q;
    endereco_escrita_d = endereco_escrita_q;
    conteudo_escrita_d = conteudo_escrita_q;
    enable_d           = 1'b0;
    zero_d             = zero_q;
    illegal_d          = illegal_q;
    retired_d          = retired_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (op_sets_zero(op)) begin
          zero_d = alu_zero;
        end
        if (op_writes(op)) begin
          endereco_escrita_d = ADDR_W'(ir_q[RD_LSB +: FIELD_W]);
          conteudo_escrita_d = alu_result;
          enable_d           = 1'b1;
          state_d            = ST_WRITE;
        end else if (op == OP_HALT) begin
          retired_d = retired_q + COUNT_W'(1);
          state_d   = ST_HALT;
        end else begin
          if (op_illegal(op)) begin
            illegal_d = 1'b1;
          end
          retired_d = retired_q + COUNT_W'(1);
          state_d   = ST_IDLE;
        end
      end

      ST_WRITE: begin
        retired_d = retired_q + COUNT_W'(1);
        state_d   = ST_IDLE;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; async reset drops any in-flight instruction and write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      ir_q               <= '0;
      endereco_escrita_q <= '0;
      conteudo_escrita_q <= '0;
      enable_q           <= 1'b0;
      zero_q             <= 1'b0;
      illegal_q          <= 1'b0;
      retired_q          <= '0;
    end else begin
      state_q            <= state_d;
      ir_q               <= ir_d;
      endereco_escrita_q <= endereco_escrita_d;
      conteudo_escrita_q <= conteudo_escrita_d;
      enable_q           <= enable_d;
      zero_q             <= zero_d;
      illegal_q          <= illegal_d;
      retired_q          <= retired_d;
    end
  end

  assign endereco_escrita = endereco_escrita_q;
  assign conteudo_escrita = conteudo_escrita_q;
  assign enable           = enable_q;
  assign zero             = zero_q;
  assign illegal          = illegal_q;
  assign halted           = (state_q == ST_HALT);
  assign retired          = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_banco.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_banco
//  Description : Bench for controle_banco with a behavioural 16x16 register
//                bank. Expected write-backs are queued at issue time and
//                checked by an independent monitor on the bank write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_banco;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  endereco_reg1, endereco_reg2, endereco_escrita;
  logic [15:0] conteudo_reg1, conteudo_reg2, conteudo_escrita;
  logic        enable, zero, illegal, halted;
  logic [15:0] retired;

  logic [15:0] regs [16];
  logic        pl_we;
  logic [3:0]  pl_a;
  logic [15:0] pl_d;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
    int          at_edge;
  } wr_t;
  wr_t exp_q[$];

  controle_banco_if bus_if();

  controle_banco dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus_if.slave),
    .endereco_reg1    (endereco_reg1),
    .endereco_reg2    (endereco_reg2),
    .conteudo_reg1    (conteudo_reg1),
    .conteudo_reg2    (conteudo_reg2),
    .endereco_escrita (endereco_escrita),
    .conteudo_escrita (conteudo_escrita),
    .enable           (enable),
    .zero             (zero),
    .illegal          (illegal),
    .halted           (halted),
    .retired          (retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: async read, sync write; bench preload port when idle
  always @(posedge clk) begin
    if (enable) regs[endereco_escrita] <= conteudo_escrita;
    else if (pl_we) regs[pl_a] <= pl_d;
  end
  assign conteudo_reg1 = regs[endereco_reg1];
  assign conteudo_reg2 = regs[endereco_reg2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest queued expectation
  always @(negedge clk) begin
    wr_t e;
    if (enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: actual addr %h data %h required no write",
                 endereco_escrita, conteudo_escrita);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {28'h0, endereco_escrita}, {28'h0, e.a});
        chk("wr_data", {16'h0, conteudo_escrita}, {16'h0, e.d});
        chk("wr_cycle", cyc, e.at_edge + 1);
      end
    end
  end

  task automatic issue(input logic [15:0] ins, input bit wr,
                       input logic [3:0] a, input logic [15:0] d);
    int k;
    wr_t e;
    @(negedge clk);
    bus_if.instr       = ins;
    bus_if.instr_valid = 1'b1;
    k = 0;
    while (bus_if.instr_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: actual no accept of %h required accept", ins);
      bus_if.instr_valid = 1'b0;
    end else begin
      if (wr) begin
        e.a = a;
        e.d = d;
        e.at_edge = cyc + 1;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus_if.instr_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (bus_if.instr_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: actual ready %b required 1", bus_if.instr_ready);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},   {31'h0, bus_if.instr_ready}, 32'h0);
    chk({tag, "_enable"},  {31'h0, enable},  32'h0);
    chk({tag, "_waddr"},   {28'h0, endereco_escrita}, 32'h0);
    chk({tag, "_wdata"},   {16'h0, conteudo_escrita}, 32'h0);
    chk({tag, "_flags"},   {29'h0, zero, illegal, halted}, 32'h0);
    chk({tag, "_retired"}, {16'h0, retired}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus_if.instr       = 16'h0000;
    bus_if.instr_valid = 1'b0;
    pl_we              = 1'b0;
    pl_a               = 4'h0;
    pl_d               = 16'h0;

    // Preload the bank while reset is held
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pl_we = 1'b1;
      pl_a  = 4'(i);
      pl_d  = 16'hA000 + 16'(i);
    end
    @(negedge clk);
    pl_we = 1'b0;

    // 1: reset state
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, bus_if.instr_ready}, 32'h1);

    // 2: LI, LI, ADD
    issue(16'h5112, 1, 4'h1, 16'h0012);
    issue(16'h5234, 1, 4'h2, 16'h0034);
    issue(16'h1312, 1, 4'h3, 16'h0046);
    wait_idle();
    chk("retired_3", {16'h0, retired}, 32'd3);

    // 3: SUB to zero, LI keeps zero, SUB wraps, AND/OR/MOV
    issue(16'h2411, 1, 4'h4, 16'h0000);
    wait_idle();
    chk("zero_sub_eq", {31'h0, zero}, 32'h1);
    issue(16'h5AFF, 1, 4'hA, 16'h00FF);
    wait_idle();
    chk("zero_kept_li", {31'h0, zero}, 32'h1);
    issue(16'h2512, 1, 4'h5, 16'hFFDE);
    wait_idle();
    chk("zero_sub_wrap", {31'h0, zero}, 32'h0);
    issue(16'h3712, 1, 4'h7, 16'h0010);
    issue(16'h4812, 1, 4'h8, 16'h0036);
    issue(16'h6920, 1, 4'h9, 16'h0034);
    wait_idle();
    chk("retired_9", {16'h0, retired}, 32'd9);
    chk("illegal_clear", {31'h0, illegal}, 32'h0);

    // 4: illegal opcode then NOP, no writes
    issue(16'h7123, 0, 4'h0, 16'h0);
    wait_idle();
    chk("illegal_set", {31'h0, illegal}, 32'h1);
    chk("retired_10", {16'h0, retired}, 32'd10);
    issue(16'h0000, 0, 4'h0, 16'h0);
    wait_idle();
    chk("illegal_sticky", {31'h0, illegal}, 32'h1);
    chk("retired_11", {16'h0, retired}, 32'd11);

    // 5: HALT, then valid held with no accept
    issue(16'hF000, 0, 4'h0, 16'h0);
    repeat (2) @(negedge clk);
    chk("halted", {31'h0, halted}, 32'h1);
    chk("halt_ready", {31'h0, bus_if.instr_ready}, 32'h0);
    chk("retired_12", {16'h0, retired}, 32'd12);
    bus_if.instr       = 16'h5B55;
    bus_if.instr_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("halt_no_accept", {31'h0, bus_if.instr_ready}, 32'h0);
    chk("halt_retired", {16'h0, retired}, 32'd12);
    chk("halt_no_write", {16'h0, regs[11]}, 32'h0000A00B);
    bus_if.instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("halt_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_halt_rst", {31'h0, bus_if.instr_ready}, 32'h1);

    // 6: reset asserted during WRITE of ADD r6
    issue(16'h1612, 0, 4'h0, 16'h0);
    @(posedge clk);
    #1;
    chk("enable_in_write", {31'h0, enable}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("enable_dropped", {31'h0, enable}, 32'h0);
    chk("retired_dropped", {16'h0, retired}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("r6_unchanged", {16'h0, regs[6]}, 32'h0000A006);

    // Final bank contents and scoreboard drain
    chk("r1", {16'h0, regs[1]},  32'h0012);
    chk("r3", {16'h0, regs[3]},  32'h0046);
    chk("r4", {16'h0, regs[4]},  32'h0000);
    chk("r5", {16'h0, regs[5]},  32'hFFDE);
    chk("r7", {16'h0, regs[7]},  32'h0010);
    chk("r8", {16'h0, regs[8]},  32'h0036);
    chk("r9", {16'h0, regs[9]},  32'h0034);
    chk("r10", {16'h0, regs[10]}, 32'h00FF);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
